// File: rtl/tt_check_pkg.sv
// tt_check_pkg: shared FSM state type, truth-table width helper and default expected table
package tt_check_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [15:0] DEFAULT_EXPECTED_TT = 16'h1AC6;
  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/tt_sync2.sv
// tt_sync2: two-flop synchronizer, async active-high reset to 0
//   clk, rst : clock and async reset
//   d        : asynchronous input
//   q        : synchronized output, two clocks behind d
module tt_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] s_q, s_d;
  always_comb s_d = {s_q[0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= '0;
    else s_q <= s_d;
  assign q = s_q[1];
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustive truth-table sweep of one N_IN-input gate, compared to EXPECTED_TT
//   start/abort        : begin / cancel a sweep (abort beats start in IDLE, ignored in DONE)
//   dut_in / dut_out   : drive the gate inputs / observe the gate output
//   busy, done, pass   : sweep in progress, one-cycle completion pulse, table matched
//   tt_out             : measured truth table (bit i = output for input value i)
//   mismatch_cnt       : popcount(tt_out ^ EXPECTED_TT)
//   TT_CHECK_SYNC_EN   : when defined, dut_out is synchronized through tt_sync2 and the
//                        settle window grows by the two synchronizer clocks
module tt_sweep_checker import tt_check_pkg::*; #(
  parameter int N_IN = 4,
  parameter int SETTLE = 2,
  parameter logic [tt_w(N_IN)-1:0] EXPECTED_TT = DEFAULT_EXPECTED_TT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [tt_w(N_IN)-1:0]   tt_out,
  output logic [N_IN:0]           mismatch_cnt
);
  localparam int TT_W = tt_w(N_IN);
  localparam int IW = N_IN + 1;
  logic sample_bit;
`ifdef TT_CHECK_SYNC_EN
  localparam int HOLD = SETTLE + 2;
  tt_sync2 u_sync (.clk(clk), .rst(rst), .d(dut_out), .q(sample_bit));
`else
  localparam int HOLD = SETTLE;
  assign sample_bit = dut_out;
`endif
  localparam int SW = $clog2(HOLD + 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, mis_q, mis_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic done_q, done_d, pass_q, pass_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    settle_d = settle_q;
    tt_d = tt_q;
    mis_d = mis_q;
    done_d = 1'b0;
    pass_d = pass_q;
    if (abort && (state_q == DRIVE || state_q == SAMPLE)) begin
      state_d = IDLE;
      idx_d = '0;
      settle_d = '0;
      pass_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start && !abort) begin
          state_d = DRIVE;
          idx_d = '0;
          settle_d = '0;
          tt_d = '0;
          mis_d = '0;
          pass_d = 1'b0;
        end
        DRIVE: begin
          state_d = (settle_q == SW'(HOLD - 1)) ? SAMPLE : DRIVE;
          settle_d = (settle_q == SW'(HOLD - 1)) ? '0 : settle_q + SW'(1);
        end
        SAMPLE: begin
          tt_d[idx_q[N_IN-1:0]] = sample_bit;
          mis_d = mis_q + IW'(sample_bit != EXPECTED_TT[idx_q[N_IN-1:0]]);
          state_d = (idx_q == IW'(TT_W - 1)) ? DONE : DRIVE;
          idx_d = (idx_q == IW'(TT_W - 1)) ? idx_q : idx_q + IW'(1);
        end
        DONE: begin
          state_d = IDLE;
          done_d = 1'b1;
          pass_d = (tt_q == EXPECTED_TT);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      settle_q <= '0;
      tt_q <= '0;
      mis_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      settle_q <= settle_d;
      tt_q <= tt_d;
      mis_q <= mis_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  assign dut_in = idx_q[N_IN-1:0];
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign pass = pass_q;
  assign tt_out = tt_q;
  assign mismatch_cnt = mis_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: randomized scoreboard bench for tt_sweep_checker
module tb_tt_sweep_checker;
  localparam logic [15:0] EXP = 16'h1AC6;
`ifdef TT_CHECK_SYNC_EN
  localparam int LAT = 81;
`else
  localparam int LAT = 49;
`endif
  localparam int PER = (LAT - 1) / 16;
  logic clk = 1'b0;
  logic rst, start, abort, dut_out, busy, done, pass;
  logic [3:0] dut_in;
  logic [15:0] tt_out, gate_tt;
  logic [4:0] mismatch_cnt;
  int cyc, total, passed;
  typedef struct {logic [15:0] tt; int mis; logic pass; int t0;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  assign dut_out = gate_tt[dut_in];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tt_sweep_checker #(.N_IN(4), .SETTLE(2), .EXPECTED_TT(EXP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .tt_out(tt_out), .mismatch_cnt(mismatch_cnt)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst && done) begin
      chk("done_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("tt_out", tt_out, mon_e.tt);
        chk("mismatch_cnt", mismatch_cnt, mon_e.mis);
        chk("pass", pass, mon_e.pass);
        chk("latency", cyc - mon_e.t0, LAT);
      end
    end

  task automatic sweep(input logic [15:0] g, input bit spur);
    gate_tt = g;
    start = 1'b1;
    tick;
    start = 1'b0;
    sb.push_back('{g, $countones(g ^ EXP), g == EXP, cyc});
    for (int c = 1; c < LAT + 20 && busy; c++) begin
      start = spur && (c == 10 || c == 30);
      tick;
    end
    start = 1'b0;
    chk("sweep_finished", busy, 0);
    tick;
    chk("pass_held", pass, g == EXP);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; gate_tt = EXP;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_tt_out", tt_out, 0);
    chk("rst_mismatch", mismatch_cnt, 0);
    chk("rst_dut_in", dut_in, 0);
    sweep(EXP, 0);
    sweep(16'h0000, 0);
    sweep(~EXP, 0);
    sweep(EXP, 1);
    repeat (4) sweep(16'($urandom), 0);
    gate_tt = EXP;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (19) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n = 19 / PER;
    chk("abort_busy", busy, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_pass", pass, 0);
    chk("abort_partial_tt", tt_out, EXP & 16'((1 << n) - 1));
    repeat (LAT + 10) tick;
    sweep(EXP, 0);
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    repeat (5) tick;
    gate_tt = ~EXP;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (24) tick;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_tt_out", tt_out, 0);
    chk("midrst_mismatch", mismatch_cnt, 0);
    chk("midrst_dut_in", dut_in, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    tick;
    rst = 1'b0;
    tick;
    sweep(16'($urandom), 0);
    sweep(EXP, 0);
    repeat (5) tick;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
